holy_axi_ram_slave: RTL and testbench

//  AXI4 slave RAM model that sits directly downstream of the core's AXI master port in the test bench/FPGA top.

---
 rtl/holy_axi_ram_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_holy_axi_ram_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/holy_axi_ram_slave.sv
// AXI4 slave RAM: single ID, one read and one write burst in flight, INCR/FIXED, byte strobes, SLVERR.
// Latency: first R beat the cycle after AR handshake, then one beat/cycle; B the cycle after the last W beat.
// Backpressure: rvalid/rdata/rlast and bvalid/bresp hold until rready/bready; W is stalled until AW is taken.
module holy_axi_ram_slave #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ID_WIDTH  = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int          AW          = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ram_q;
    logic        live;

    // The 33-bit difference exposes addr < BASE_ADDR as a borrow.
    logic [32:0] aw_diff, ar_diff;
    logic [31:0] aw_word, ar_word;
    logic        aw_req_err, ar_req_err;
    logic        addr_lsb_unused;

    assign aw_diff         = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
    assign ar_diff         = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
    assign aw_word         = {2'b00, aw_diff[31:2]};
    assign ar_word         = {2'b00, ar_diff[31:2]};
    assign aw_req_err      = (s_axi_awsize != 3'b010) || s_axi_awburst[1] || aw_diff[32];
    assign ar_req_err      = (s_axi_arsize != 3'b010) || s_axi_arburst[1] || ar_diff[32];
    assign addr_lsb_unused = ^{aw_diff[1:0], ar_diff[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) live <= 1'b0;
        else          live <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_t            w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [7:0]          w_len, w_cnt;
    logic                w_fixed, w_req_err, w_err;
    logic [31:0]         w_word;
    logic                aw_hs, w_beat, w_beat_err, w_last_beat;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_beat      = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = w_req_err || (w_word >= MEM_WORDS_W);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = live;
                if (s_axi_awvalid && live) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_axi_bid   = s_axi_bvalid ? w_id : '0;
    assign s_axi_bresp = (s_axi_bvalid && w_err) ? 2'b10 : 2'b00;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id      <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_fixed   <= 1'b0;
            w_req_err <= 1'b0;
            w_err     <= 1'b0;
            w_word    <= '0;
        end else if (aw_hs) begin
            w_id      <= s_axi_awid;
            w_len     <= s_axi_awlen;
            w_cnt     <= '0;
            w_fixed   <= (s_axi_awburst == 2'b00);
            w_req_err <= aw_req_err;
            w_err     <= 1'b0;
            w_word    <= aw_word;
        end else if (w_beat) begin
            // The beat count, not wlast, closes the burst; a disagreeing wlast only flags SLVERR.
            w_err <= w_err || w_beat_err || (s_axi_wlast != w_last_beat);
            if (!w_last_beat) begin
                w_cnt  <= w_cnt + 8'd1;
                w_word <= w_fixed ? w_word : w_word + 32'd1;
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t            r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [7:0]          r_len, r_cnt;
    logic                r_fixed, r_req_err, r_beat_err;
    logic [31:0]         r_word;
    logic                fetch_en, fetch_err;
    logic [31:0]         fetch_word;
    logic                r_last_beat;

    assign r_last_beat = (r_cnt == r_len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Next beat is fetched on the handshake so data is ready the following cycle.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        fetch_en      = 1'b0;
        fetch_word    = r_word;
        fetch_err     = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = live;
                if (s_axi_arvalid && live) begin
                    r_next     = R_DATA;
                    fetch_en   = 1'b1;
                    fetch_word = ar_word;
                    fetch_err  = ar_req_err || (ar_word >= MEM_WORDS_W);
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    if (r_last_beat) begin
                        r_next = R_IDLE;
                    end else begin
                        fetch_en   = 1'b1;
                        fetch_word = r_fixed ? r_word : r_word + 32'd1;
                        fetch_err  = r_req_err || (fetch_word >= MEM_WORDS_W);
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_fixed    <= 1'b0;
            r_req_err  <= 1'b0;
            r_beat_err <= 1'b0;
            r_word     <= '0;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                r_id      <= s_axi_arid;
                r_len     <= s_axi_arlen;
                r_cnt     <= '0;
                r_fixed   <= (s_axi_arburst == 2'b00);
                r_req_err <= ar_req_err;
            end else if (s_axi_rvalid && s_axi_rready && !r_last_beat) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (fetch_en) begin
                r_word     <= fetch_word;
                r_beat_err <= fetch_err;
            end
        end
    end

    assign s_axi_rid   = s_axi_rvalid ? r_id : '0;
    assign s_axi_rdata = (s_axi_rvalid && !r_beat_err) ? ram_q : 32'h0;
    assign s_axi_rresp = (s_axi_rvalid && r_beat_err) ? 2'b10 : 2'b00;
    assign s_axi_rlast = s_axi_rvalid && r_last_beat;

    // Non-blocking update gives read-old behaviour when fetch and commit hit the same word.
    always_ff @(posedge aclk) begin
        if (w_beat && !w_beat_err) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axi_wstrb[i]) mem[w_word[AW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
        if (fetch_en && !fetch_err) ram_q <= mem[fetch_word[AW-1:0]];
    end

endmodule

// File: tb/tb_holy_axi_ram_slave.sv
// Directed bench for holy_axi_ram_slave: reset, strobed writes, INCR/FIXED bursts, errors, mid-burst reset.
module tb_holy_axi_ram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wbuf  [256];
    logic [31:0] rbuf  [256];
    logic [1:0]  rrbuf [256];
    logic        rlbuf [256];
    logic [1:0]  resp;

    holy_axi_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .ID_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Tasks enter and leave 1 time unit after a rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input int early, input int bdelay, output logic [1:0] r);
        int t;
        r = 2'b11;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        if (t >= 50) check("aw_timeout", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb;
            wlast = (early >= 0) ? (i == early) : (i == int'(len));
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            if (t >= 50) begin
                check("wready_timeout", 32'(wready), 32'd1);
                break;
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin tick(); t++; end
        if (t >= 50) check("bvalid_timeout", 32'(bvalid), 32'd1);
        for (int k = 0; k < bdelay; k++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            tick();
        end
        bready = 1'b1;
        r = bresp;
        check("bid", 32'(bid), 32'(id));
        tick();
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        int t, beat, cyc;
        bit hold;
        logic [31:0] hd;
        logic hl;
        logic [1:0] hr;
        hold = 1'b0; hd = '0; hl = 1'b0; hr = '0;
        arid = id; araddr = addr; arlen = len; arsize = 3'b010; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        if (t >= 50) check("ar_timeout", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid_latency", 32'(rvalid), 32'd1);
        check("rid", 32'(rid), 32'(id));
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 600) begin
            if (hold) begin
                check("rdata_hold", rdata, hd);
                check("rlast_hold", 32'(rlast), 32'(hl));
                check("rresp_hold", 32'(rresp), 32'(hr));
                hold = 1'b0;
            end
            rready = toggle ? ~cyc[0] : 1'b1;
            if (rvalid && rready) begin
                rbuf[beat] = rdata; rrbuf[beat] = rresp; rlbuf[beat] = rlast;
                beat++;
            end else if (rvalid) begin
                hold = 1'b1; hd = rdata; hl = rlast; hr = rresp;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 600) check("r_timeout", 32'(beat), 32'(len) + 32'd1);
    endtask

    initial begin
        // 1: reset
        repeat (3) tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_outs",    {bid, bresp, rid, rresp, 19'd0, rlast}, 32'd0);
        aresetn = 1'b1;
        check("rel_awready_same", 32'(awready), 32'd0);
        tick();
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        // 2: strobed partial write over known word
        wbuf[0] = 32'h1122_3344;
        do_write(4'h3, 32'h10, 8'd0, 3'b010, 2'b01, 4'b1111, -1, 0, resp);
        check("w_prior_bresp", 32'(resp), 32'd0);
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(4'h5, 32'h10, 8'd0, 3'b010, 2'b01, 4'b0011, -1, 0, resp);
        check("w_strb_bresp", 32'(resp), 32'd0);
        do_read(4'h9, 32'h10, 8'd0, 2'b01, 1'b0);
        check("r_strb_data", rbuf[0], 32'h1122_BEEF);
        check("r_strb_last", 32'(rlbuf[0]), 32'd1);
        check("r_strb_resp", 32'(rrbuf[0]), 32'd0);

        // 3: INCR burst write/read, rready toggling
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
        do_write(4'h1, 32'h40, 8'd7, 3'b010, 2'b01, 4'b1111, -1, 0, resp);
        check("incr_bresp", 32'(resp), 32'd0);
        do_read(4'h2, 32'h40, 8'd7, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("incr_data", rbuf[i], 32'(i));
            check("incr_last", 32'(rlbuf[i]), (i == 7) ? 32'd1 : 32'd0);
        end

        // FIXED read repeats one word
        do_read(4'h4, 32'h44, 8'd2, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) check("fixed_data", rbuf[i], 32'd1);

        // 4: out-of-range read, illegal-size write
        do_read(4'h6, 32'h0000_1000, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("oor_data", rbuf[i], 32'd0);
            check("oor_resp", 32'(rrbuf[i]), 32'd2);
        end
        check("oor_last", 32'(rlbuf[3]), 32'd1);
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(4'h7, 32'h40, 8'd0, 3'b000, 2'b01, 4'b1111, -1, 0, resp);
        check("badsize_bresp", 32'(resp), 32'd2);
        do_read(4'h7, 32'h40, 8'd0, 2'b01, 1'b0);
        check("badsize_mem", rbuf[0], 32'd0);

        // 5: early wlast, delayed bready
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(4'hA, 32'h80, 8'd3, 3'b010, 2'b01, 4'b1111, 2, 5, resp);
        check("early_wlast_bresp", 32'(resp), 32'd2);
        do_read(4'hB, 32'h80, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check("early_wlast_data", rbuf[i], 32'hA0 + 32'(i));

        // 6: reset in the middle of a 16-beat read
        arid = 4'hC; araddr = 32'h40; arlen = 8'd15; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (3) tick();
        check("mid_beat3_data", rdata, 32'd3);
        aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        rready = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        do_read(4'hD, 32'h44, 8'd0, 2'b01, 1'b0);
        check("post_rst_data", rbuf[0], 32'd1);
        check("post_rst_last", 32'(rlbuf[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
